// File: rtl/alu_rr_arbiter.sv
// ============================================================================
// Module   : alu_rr_arbiter
// Purpose  : Round-robin sharing of one external combinational ALU between two
//            valid/ready requesters (A, B). Optional statistics counters are
//            built when ALU_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_arbiter #(
    parameter int DW    = 5,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             a_req_valid,
    output logic             a_req_ready,
    input  logic [DW-1:0]    a_req_x,
    input  logic [DW-1:0]    a_req_y,
    input  logic [SEL_W-1:0] a_req_op,

    input  logic             b_req_valid,
    output logic             b_req_ready,
    input  logic [DW-1:0]    b_req_x,
    input  logic [DW-1:0]    b_req_y,
    input  logic [SEL_W-1:0] b_req_op,

    output logic [DW-1:0]    alu_x,
    output logic [DW-1:0]    alu_y,
    output logic [SEL_W-1:0] alu_s,
    input  logic [DW-1:0]    alu_f,
    input  logic             alu_cout,
    input  logic             alu_ovf,

    output logic             a_rsp_valid,
    input  logic             a_rsp_ready,
    output logic             b_rsp_valid,
    input  logic             b_rsp_ready,
    output logic [DW-1:0]    rsp_f,
    output logic             rsp_cout,
    output logic             rsp_ovf,

`ifdef ALU_ARB_STATS_EN
    output logic [CNT_W-1:0] a_ops_cnt,
    output logic [CNT_W-1:0] b_ops_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_owner_b;
    logic             r_last_b;
    logic [DW-1:0]    r_alu_x;
    logic [DW-1:0]    r_alu_y;
    logic [SEL_W-1:0] r_alu_s;
    logic [DW-1:0]    r_rsp_f;
    logic             r_rsp_cout;
    logic             r_rsp_ovf;

    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_rsp_hs;

    assign w_rsp_hs = (r_state == RESP) && (r_owner_b ? b_rsp_ready : a_rsp_ready);

    // Round-robin: on contention the requester that did not win last time goes.
    always_comb begin
        w_next    = r_state;
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        case (r_state)
            IDLE: begin
                if (a_req_valid && b_req_valid) begin
                    w_grant_a = r_last_b;
                    w_grant_b = !r_last_b;
                end else begin
                    w_grant_a = a_req_valid;
                    w_grant_b = b_req_valid;
                end
                if (a_req_valid || b_req_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: w_next = RESP;
            RESP: begin
                if (w_rsp_hs) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner_b  <= 1'b0;
            r_last_b   <= 1'b1;
            r_alu_x    <= '0;
            r_alu_y    <= '0;
            r_alu_s    <= '0;
            r_rsp_f    <= '0;
            r_rsp_cout <= 1'b0;
            r_rsp_ovf  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant_a || w_grant_b) begin
                r_owner_b <= w_grant_b;
                r_last_b  <= w_grant_b;
                r_alu_x   <= w_grant_b ? b_req_x  : a_req_x;
                r_alu_y   <= w_grant_b ? b_req_y  : a_req_y;
                r_alu_s   <= w_grant_b ? b_req_op : a_req_op;
            end
            if (r_state == ISSUE) begin
                r_rsp_f    <= alu_f;
                r_rsp_cout <= alu_cout;
                r_rsp_ovf  <= alu_ovf;
            end
        end
    end

    // Ready is gated by rst so nothing is accepted on a reset edge.
    assign a_req_ready = w_grant_a && !rst;
    assign b_req_ready = w_grant_b && !rst;

    assign alu_x       = r_alu_x;
    assign alu_y       = r_alu_y;
    assign alu_s       = r_alu_s;
    assign rsp_f       = r_rsp_f;
    assign rsp_cout    = r_rsp_cout;
    assign rsp_ovf     = r_rsp_ovf;
    assign a_rsp_valid = (r_state == RESP) && !r_owner_b;
    assign b_rsp_valid = (r_state == RESP) &&  r_owner_b;
    assign busy        = (r_state != IDLE);

`ifdef ALU_ARB_STATS_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] r_a_cnt;
    logic [CNT_W-1:0] r_b_cnt;
    logic [CNT_W-1:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_cnt   <= '0;
            r_b_cnt   <= '0;
            r_ovf_cnt <= '0;
        end else if (w_rsp_hs) begin
            if (!r_owner_b && (r_a_cnt != C_CNT_MAX)) begin
                r_a_cnt <= r_a_cnt + CNT_W'(1);
            end
            if (r_owner_b && (r_b_cnt != C_CNT_MAX)) begin
                r_b_cnt <= r_b_cnt + CNT_W'(1);
            end
            if (r_rsp_ovf && (r_ovf_cnt != C_CNT_MAX)) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
        end
    end

    assign a_ops_cnt = r_a_cnt;
    assign b_ops_cnt = r_b_cnt;
    assign ovf_cnt   = r_ovf_cnt;
`else
    if (CNT_W > 0) begin : g_stats_off
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
// ============================================================================
// Module   : tb_alu_rr_arbiter
// Purpose  : Self-checking bench for alu_rr_arbiter with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req_valid, b_req_valid, a_req_ready, b_req_ready;
    logic [4:0] a_req_x, a_req_y, b_req_x, b_req_y;
    logic [1:0] a_req_op, b_req_op;
    logic [4:0] alu_x, alu_y, alu_f;
    logic [1:0] alu_s;
    logic       alu_cout, alu_ovf;
    logic       a_rsp_valid, a_rsp_ready, b_rsp_valid, b_rsp_ready;
    logic [4:0] rsp_f;
    logic       rsp_cout, rsp_ovf, busy;
`ifdef ALU_ARB_STATS_EN
    logic [1:0] a_ops_cnt, b_ops_cnt, ovf_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: 00 AND, 01 unsigned compare (x>y), 10 add, 11 subtract.
    function automatic logic [6:0] alu_model(input logic [1:0] op, input logic [4:0] x,
                                             input logic [4:0] y);
        logic [5:0] t;
        logic [4:0] f;
        logic       c, o;
        f = 5'd0; c = 1'b0; o = 1'b0;
        case (op)
            2'b00: f = x & y;
            2'b01: c = (x > y);
            2'b10: begin
                t = {1'b0, x} + {1'b0, y};
                f = t[4:0]; c = t[5];
                o = (x[4] == y[4]) && (f[4] != x[4]);
            end
            default: begin
                f = x - y; c = (x < y);
                o = (x[4] != y[4]) && (f[4] != x[4]);
            end
        endcase
        return {f, c, o};
    endfunction

    assign {alu_f, alu_cout, alu_ovf} = alu_model(alu_s, alu_x, alu_y);

    alu_rr_arbiter #(.DW(5), .SEL_W(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
        .a_req_x(a_req_x), .a_req_y(a_req_y), .a_req_op(a_req_op),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
        .b_req_x(b_req_x), .b_req_y(b_req_y), .b_req_op(b_req_op),
        .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
`ifdef ALU_ARB_STATS_EN
        .a_ops_cnt(a_ops_cnt), .b_ops_cnt(b_ops_cnt), .ovf_cnt(ovf_cnt),
`endif
        .busy(busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: {owner_b, f, cout, ovf} pushed on accept, popped on response handshake.
    logic [7:0] sb[$];

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (a_rsp_valid && b_rsp_valid) chk("both_rsp_valid", 1, 0);
            if ((a_rsp_valid && a_rsp_ready) || (b_rsp_valid && b_rsp_ready)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 1, 0);
                end else begin
                    logic [7:0] e;
                    e = sb.pop_front();
                    chk("sb_owner", int'(b_rsp_valid), int'(e[7]));
                    chk("sb_result", int'({rsp_f, rsp_cout, rsp_ovf}), int'(e[6:0]));
                end
            end
            if (a_req_valid && a_req_ready)
                sb.push_back({1'b0, alu_model(a_req_op, a_req_x, a_req_y)});
            if (b_req_valid && b_req_ready)
                sb.push_back({1'b1, alu_model(b_req_op, b_req_x, b_req_y)});
        end
    end

    typedef struct {
        bit         own_b;
        logic [4:0] x, y;
        logic [1:0] op;
        logic [4:0] f;
        bit         c, o;
    } vec_t;

    // Single-requester operation: checks accept, 2-cycle latency, and returned values.
    task automatic run_vec(input vec_t v, input string tag);
        bit rdy;
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        if (v.own_b) begin
            b_req_valid = 1'b1; b_req_x = v.x; b_req_y = v.y; b_req_op = v.op;
        end else begin
            a_req_valid = 1'b1; a_req_x = v.x; a_req_y = v.y; a_req_op = v.op;
        end
        #1;
        rdy = 1'b0;
        for (int k = 0; k < 10 && !rdy; k++) begin
            rdy = v.own_b ? b_req_ready : a_req_ready;
            if (!rdy) step();
        end
        chk({tag, "_accept"}, int'(rdy), 1);
        chk({tag, "_other_ready"}, int'(v.own_b ? a_req_ready : b_req_ready), 0);
        step();
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        #1;
        chk({tag, "_issue_busy"}, int'(busy), 1);
        chk({tag, "_issue_novalid"}, int'(a_rsp_valid | b_rsp_valid), 0);
        step();
        chk({tag, "_rsp_valid"}, int'(v.own_b ? b_rsp_valid : a_rsp_valid), 1);
        chk({tag, "_rsp_other"}, int'(v.own_b ? a_rsp_valid : b_rsp_valid), 0);
        chk({tag, "_rsp_val"}, int'({rsp_f, rsp_cout, rsp_ovf}), int'({v.f, v.c, v.o}));
        step();
        chk({tag, "_done_idle"}, int'(busy | a_rsp_valid | b_rsp_valid), 0);
    endtask

    vec_t tbl[10];
    int   grants[$];
    int   acc[$];

    initial begin
        tbl[0] = '{0, 5'd7,  5'd9,  2'b10, 5'd16, 0, 1};
        tbl[1] = '{0, 5'd12, 5'd3,  2'b01, 5'd0,  1, 0};
        tbl[2] = '{1, 5'd13, 5'd7,  2'b00, 5'd5,  0, 0};
        tbl[3] = '{1, 5'd31, 5'd1,  2'b10, 5'd0,  1, 0};
        tbl[4] = '{0, 5'd16, 5'd16, 2'b10, 5'd0,  1, 1};
        tbl[5] = '{1, 5'd3,  5'd12, 2'b01, 5'd0,  0, 0};
        tbl[6] = '{0, 5'd5,  5'd9,  2'b11, 5'd28, 1, 0};
        tbl[7] = '{1, 5'd16, 5'd1,  2'b11, 5'd15, 0, 1};
        tbl[8] = '{0, 5'd15, 5'd15, 2'b11, 5'd0,  0, 0};
        tbl[9] = '{1, 5'd31, 5'd31, 2'b00, 5'd31, 0, 0};

        rst = 1'b1;
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        a_req_x = 5'd1; a_req_y = 5'd2; a_req_op = 2'b10;
        b_req_x = 5'd3; b_req_y = 5'd4; b_req_op = 2'b11;
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        #1;
        chk("rst_ready", int'({a_req_ready, b_req_ready}), 0);
        step(); step();
        chk("rst_ready2", int'({a_req_ready, b_req_ready}), 0);
        chk("rst_alu", int'({alu_x, alu_y, alu_s}), 0);
        chk("rst_rsp", int'({rsp_f, rsp_cout, rsp_ovf}), 0);
        chk("rst_flags", int'({a_rsp_valid, b_rsp_valid, busy}), 0);

        // Contention from reset: both held valid, grants alternate A, B, A, B.
        a_req_x = 5'd12; a_req_y = 5'd3;  a_req_op = 2'b01;
        b_req_x = 5'd13; b_req_y = 5'd7;  b_req_op = 2'b00;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 30 && grants.size() < 4; k++) begin
            if (a_req_ready) grants.push_back(0);
            if (b_req_ready) grants.push_back(1);
            if (a_req_valid && a_rsp_valid) chk("cont_rsp_a", int'({rsp_f, rsp_cout}), 1);
            step();
        end
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        chk("cont_ngrants", grants.size(), 4);
        for (int k = 0; k < grants.size(); k++) chk("cont_order", grants[k], k % 2);
        repeat (4) step();

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Stalled A response blocks B.
        a_req_valid = 1'b1; a_req_x = 5'd7; a_req_y = 5'd9; a_req_op = 2'b10;
        b_req_valid = 1'b1; b_req_x = 5'd5; b_req_y = 5'd9; b_req_op = 2'b11;
        a_rsp_ready = 1'b0;
        #1;
        chk("stall_a_first", int'({a_req_ready, b_req_ready}), 2);
        step();
        a_req_valid = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", int'(a_rsp_valid), 1);
            chk("stall_rsp", int'({rsp_f, rsp_cout, rsp_ovf}), int'({5'd16, 1'b0, 1'b1}));
            chk("stall_b_ready", int'(b_req_ready), 0);
            step();
        end
        a_rsp_ready = 1'b1;
        #1;
        step();
        chk("stall_release_a", int'(a_rsp_valid), 0);
        chk("stall_b_accept", int'(b_req_ready), 1);
        step();
        b_req_valid = 1'b0;
        repeat (4) step();

        // Reset while the operation sits in ISSUE.
        a_req_valid = 1'b1; a_req_x = 5'd7; a_req_y = 5'd9; a_req_op = 2'b10;
        #1;
        chk("rsti_accept", int'(a_req_ready), 1);
        step();
        a_req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rsti_alu", int'({alu_x, alu_y, alu_s}), 0);
        chk("rsti_rsp", int'({rsp_f, rsp_cout, rsp_ovf}), 0);
        chk("rsti_flags", int'({a_rsp_valid, b_rsp_valid, busy}), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rsti_no_rsp", int'({a_rsp_valid, b_rsp_valid}), 0);
        end
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        #1;
        chk("rsti_grant_a", int'({a_req_ready, b_req_ready}), 2);
        step();
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        repeat (3) step();
        b_req_valid = 1'b1;
        #1;
        step();
        b_req_valid = 1'b0;
        repeat (4) step();

        // Back-to-back A: accepts every 3 cycles, busy low only on accept cycles.
        a_req_valid = 1'b1; a_req_x = 5'd1; a_req_y = 5'd2; a_req_op = 2'b10;
        #1;
        for (int k = 0; k < 40 && acc.size() < 4; k++) begin
            if (a_req_ready) acc.push_back(k);
            if (acc.size() > 0) chk("btb_busy", int'(busy), int'(!a_req_ready));
            step();
        end
        a_req_valid = 1'b0;
        chk("btb_naccept", acc.size(), 4);
        for (int k = 1; k < acc.size(); k++) chk("btb_spacing", acc[k] - acc[k-1], 3);
        repeat (4) step();

`ifdef ALU_ARB_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stats_rst", int'({a_ops_cnt, b_ops_cnt, ovf_cnt}), 0);
        run_vec('{0, 5'd7,  5'd9,  2'b10, 5'd16, 0, 1}, "st0");
        run_vec('{0, 5'd1,  5'd2,  2'b10, 5'd3,  0, 0}, "st1");
        run_vec('{0, 5'd16, 5'd16, 2'b10, 5'd0,  1, 1}, "st2");
        run_vec('{0, 5'd4,  5'd2,  2'b10, 5'd6,  0, 0}, "st3");
        run_vec('{0, 5'd3,  5'd3,  2'b10, 5'd6,  0, 0}, "st4");
        chk("stats_a", int'(a_ops_cnt), 3);
        chk("stats_ovf", int'(ovf_cnt), 2);
        chk("stats_b", int'(b_ops_cnt), 0);
`endif

        step();
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational 5-bit ALU (X, Y, S in; F, Cout, Overflow out) between two requesters, A and B.
- Arbitration is round-robin; each accepted operation is issued to the ALU, and the ALU outputs are captured into a result register.
- The result is returned on the owning requester's response channel with a valid/ready handshake.
- Sits between the two operation sources and the ALU instance. The ALU itself is external.

Parameters:
- DW, 5, operand/result width (must match the ALU).
- SEL_W, 2, ALU op-select width.
- CNT_W, 8, width of the statistics counters (used only with ALU_ARB_STATS_EN).

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req_valid  in  1  requester A operation valid.
- a_req_ready  out  1  A operation accepted this cycle.
- a_req_x, a_req_y  in  DW  A operands.
- a_req_op  in  SEL_W  A ALU select.
- b_req_valid, b_req_ready, b_req_x, b_req_y, b_req_op: same as A, for requester B.
- alu_x, alu_y  out  DW  operands driven to the ALU.
- alu_s  out  SEL_W  select driven to the ALU.
- alu_f  in  DW  ALU result.
- alu_cout  in  1  ALU carry/compare flag.
- alu_ovf  in  1  ALU overflow.
- a_rsp_valid  out  1  A result valid.
- a_rsp_ready  in  1  A result consumed.
- b_rsp_valid  out  1  B result valid.
- b_rsp_ready  in  1  B result consumed.
- rsp_f  out  DW  result (shared by both channels).
- rsp_cout  out  1  carry/compare flag (shared).
- rsp_ovf  out  1  overflow (shared).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (rst high at a clock edge):
  - state=IDLE, last_grant=B (so A wins first contention).
  - alu_x/alu_y/alu_s = 0.
  - rsp_f/rsp_cout/rsp_ovf = 0.
  - a/b_rsp_valid = 0, busy = 0.
  - a/b_req_ready are forced 0 while rst is high.
- State machine: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE, arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: stay in IDLE.
- IDLE, on a grant:
  - x_req_ready=1 combinationally in that cycle for the winner only.
  - At the edge: latch operands/op into alu_x/alu_y/alu_s, record owner, set last_grant=owner, go to ISSUE.
- ISSUE (one cycle): ALU inputs are stable from the registers. At the end-of-cycle edge, capture alu_f/alu_cout/alu_ovf into rsp_* and go to RESP.
- RESP:
  - Owner's x_rsp_valid=1; the other channel's rsp_valid stays 0. rsp_* and alu_* are held.
  - On x_rsp_ready=1: rsp_valid drops at the next edge and the state returns to IDLE.
  - A stalled response blocks both requesters indefinitely.
- Latency and throughput:
  - Accept at edge T; rsp_valid visible in the cycle after edge T+1. That is 2 cycles, request-accept to response-valid.
  - Peak throughput is one operation per 3 cycles. There is no accept in the same cycle as a response handshake.
- req_ready is never asserted outside IDLE. A requester holding valid keeps its operands stable until ready, as usual for valid/ready.
- The block passes values through unmodified and is unaware of op semantics.
- rsp_* are also left unchanged outside RESP; only the rsp_valid flags qualify them.
- Reset mid-operation (ISSUE or RESP): the in-flight operation is dropped and no response is produced. All registers take reset values on that edge.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined: adds outputs a_ops_cnt and b_ops_cnt (CNT_W bits each), plus ovf_cnt (CNT_W bits).
  - The per-requester counter increments on each completed response handshake.
  - ovf_cnt increments on each completed handshake with rsp_ovf=1.
  - All counters saturate at 2^CNT_W-1 and reset to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Only A valid, op=10, x=7, y=9; a_rsp_ready=1 -> a_req_ready pulses 1 cycle. Two cycles later a_rsp_valid=1 with rsp_f=5'b10000, cout=0, ovf=1. b_rsp_valid stays 0.
- A and B valid together from reset; A: op=01, x=12, y=3; B: op=00 -> A granted first (rsp_f=0, cout=1), then B granted in the next IDLE. With both held valid continuously, grants alternate A, B, A, B.
- a_rsp_ready held 0 for 5 cycles in RESP while B is valid -> a_rsp_valid and rsp_* stay stable, b_req_ready stays 0. Release -> B accepted in the following IDLE cycle.
- rst pulsed in ISSUE -> no rsp_valid on either channel; all outputs 0 next cycle; the next contention grants A.
- Back-to-back A requests with rsp_ready=1 -> accepts spaced exactly 3 cycles apart; busy low for exactly 1 cycle between operations.
- With ALU_ARB_STATS_EN and CNT_W=2: 5 A operations of which 2 overflow -> a_ops_cnt saturates at 3, ovf_cnt=2, b_ops_cnt=0.
